// File: rtl/dm_pkg.sv
// Shared debug-module types for the system bus access engine.
package dm;

  typedef enum logic [2:0] {
    SbaIdle,
    SbaRead,
    SbaWrite,
    SbaWaitRead,
    SbaWaitWrite
  } sba_state_e;

  typedef enum logic [2:0] {
    SbErrNone    = 3'd0,
    SbErrTimeout = 3'd1,
    SbErrAlign   = 3'd3,
    SbErrSize    = 3'd4,
    SbErrOther   = 3'd7
  } sberror_e;

  typedef enum logic [1:0] {
    Size8  = 2'd0,
    Size16 = 2'd1,
    Size32 = 2'd2
  } sbaccess_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic sba_misaligned(input sbaccess_e size, input logic [1:0] offset);
    return ((size == Size16) && offset[0]) || ((size == Size32) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering for one single-beat 32-bit bus access: byte enables,
// write-data replication and right-aligned, zero-extended read data.
module dm_sba_lane
  import dm::*;
(
  input  sbaccess_e   i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_be    = 4'hF;
    o_wdata = i_wdata;
    o_rdata = w_shifted;
    case (i_size)
      Size8: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h0, w_shifted[7:0]};
      end
      Size16: begin
        o_be    = 4'b0011 << i_offset;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_sba_master.sv
// System bus access engine: starts one single-beat read or write from DM CSR
// triggers, tracks it to completion and reports data, address increment and errors.
module dm_sba_master
  import dm::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [BusWidth-1:0] sbaddress_i,
  input  logic                sbaddress_wr_i,
  input  logic [BusWidth-1:0] sbdata_i,
  input  logic                sbdata_wr_i,
  input  logic                sbdata_rd_i,
  input  logic                sbreadonaddr_i,
  input  logic                sbreadondata_i,
  input  logic                sbautoinc_i,
  input  logic [2:0]          sbaccess_i,
  input  logic                sberror_sticky_i,
  output logic                sbbusy_o,
  output logic [BusWidth-1:0] sbaddress_o,
  output logic                sbaddress_upd_o,
  output logic [BusWidth-1:0] sbdata_o,
  output logic                sbdata_valid_o,
  output logic [2:0]          sberror_o,
  output logic                sberror_valid_o,
  output logic                req_o,
  output logic [BusWidth-1:0] addr_o,
  output logic                we_o,
  output logic [BusWidth-1:0] wdata_o,
  output logic [3:0]          be_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [BusWidth-1:0] rdata_i,
  input  logic                rerr_i
);

  sba_state_e  r_state, w_state_d;
  sbaccess_e   r_size, w_start_size;
  sberror_e    r_err, w_err_d;
  logic [31:0] r_addr, r_data, r_rdata, r_cnt, w_start_addr;
  logic        r_upd, r_data_valid, r_err_valid;
  logic        w_upd_d, w_data_valid_d, w_err_valid_d;
  logic        w_wr_trig, w_rd_trig, w_trig, w_misaligned, w_start_ok;
  logic        w_req, w_busy, w_is_read, w_timeout, w_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata;

  assign w_wr_trig    = sbdata_wr_i;
  assign w_rd_trig    = (sbaddress_wr_i & sbreadonaddr_i) | (sbdata_rd_i & sbreadondata_i);
  assign w_trig       = (r_state == SbaIdle) & ~sberror_sticky_i & (w_wr_trig | w_rd_trig);
  assign w_start_addr = sbaddress_wr_i ? sbaddress_i : r_addr;
  assign w_start_size = sbaccess_e'(sbaccess_i[1:0]);
  assign w_misaligned = sba_misaligned(w_start_size, w_start_addr[1:0]);
  assign w_start_ok   = w_trig & (sbaccess_i <= 3'd2) & ~w_misaligned;

  assign w_req     = (r_state == SbaRead) | (r_state == SbaWrite);
  assign w_busy    = r_state != SbaIdle;
  assign w_is_read = (r_state == SbaRead) | (r_state == SbaWaitRead);
  assign w_timeout = (TimeoutCycles != 0) && (r_cnt == 32'(TimeoutCycles - 1));

  dm_sba_lane u_lane (
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .i_wdata  (r_data),
    .i_rdata  (rdata_i),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  always_comb begin
    w_state_d      = r_state;
    w_err_valid_d  = 1'b0;
    w_err_d        = SbErrNone;
    w_data_valid_d = 1'b0;
    w_upd_d        = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      SbaIdle: begin
        if (w_trig) begin
          if (sbaccess_i > 3'd2) begin
            w_err_valid_d = 1'b1;
            w_err_d       = SbErrSize;
          end else if (w_misaligned) begin
            w_err_valid_d = 1'b1;
            w_err_d       = SbErrAlign;
          end else begin
            w_state_d = w_wr_trig ? SbaWrite : SbaRead;
          end
        end
      end
      SbaRead, SbaWrite: begin
        // A same-cycle grant and response completes here without a wait state.
        if (gnt_i && rvalid_i) begin
          w_done = 1'b1;
        end else if (w_timeout) begin
          w_state_d     = SbaIdle;
          w_err_valid_d = 1'b1;
          w_err_d       = SbErrTimeout;
        end else if (gnt_i) begin
          w_state_d = (r_state == SbaRead) ? SbaWaitRead : SbaWaitWrite;
        end
      end
      SbaWaitRead, SbaWaitWrite: begin
        if (rvalid_i) begin
          w_done = 1'b1;
        end else if (w_timeout) begin
          w_state_d     = SbaIdle;
          w_err_valid_d = 1'b1;
          w_err_d       = SbErrTimeout;
        end
      end
      default: w_state_d = SbaIdle;
    endcase
    if (w_done) begin
      w_state_d = SbaIdle;
      if (rerr_i) begin
        w_err_valid_d = 1'b1;
        w_err_d       = SbErrOther;
      end else begin
        w_data_valid_d = w_is_read;
        w_upd_d        = sbautoinc_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) r_state <= SbaIdle;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_size       <= Size8;
      r_err        <= SbErrNone;
      r_upd        <= 1'b0;
      r_data_valid <= 1'b0;
      r_err_valid  <= 1'b0;
    end else begin
      r_upd        <= w_upd_d;
      r_data_valid <= w_data_valid_d;
      r_err_valid  <= w_err_valid_d;
      r_err        <= w_err_d;
      if (w_data_valid_d) r_rdata <= w_rdata;
      // Address writes during a transfer are ignored; the CSR block reports them.
      if (w_upd_d)                                   r_addr <= r_addr + (32'd1 << r_size);
      else if ((r_state == SbaIdle) && sbaddress_wr_i) r_addr <= sbaddress_i;
      if (w_start_ok) begin
        r_size <= w_start_size;
        r_data <= sbdata_i;
        r_cnt  <= '0;
      end else if (w_busy && (TimeoutCycles != 0)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign sbbusy_o        = w_busy;
  assign sbaddress_o     = r_addr;
  assign sbaddress_upd_o = r_upd;
  assign sbdata_o        = r_rdata;
  assign sbdata_valid_o  = r_data_valid;
  assign sberror_o       = r_err;
  assign sberror_valid_o = r_err_valid;
  assign req_o           = w_req;
  assign addr_o          = w_req ? r_addr : '0;
  assign we_o            = r_state == SbaWrite;
  assign wdata_o         = (r_state == SbaWrite) ? w_wdata : '0;
  assign be_o            = w_req ? w_be : 4'h0;

endmodule

// File: tb/tb_dm_sba_master.sv
// Directed bench for dm_sba_master: table of single-beat reads plus hand-written
// write, bus-error, timeout, reset-abort and busy-trigger sequences.
module tb_dm_sba_master;
  import dm::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] sbaddress_i, sbdata_i, rdata_i;
  logic        sbaddress_wr_i, sbdata_wr_i, sbdata_rd_i;
  logic        sbreadonaddr_i, sbreadondata_i, sbautoinc_i, sberror_sticky_i;
  logic [2:0]  sbaccess_i;
  logic        gnt_i, rvalid_i, rerr_i;
  logic        sbbusy_o, sbaddress_upd_o, sbdata_valid_o, sberror_valid_o, req_o, we_o;
  logic [31:0] sbaddress_o, sbdata_o, addr_o, wdata_o;
  logic [2:0]  sberror_o;
  logic [3:0]  be_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_sba_master #(.BusWidth(32), .TimeoutCycles(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .sbaddress_i      (sbaddress_i),
    .sbaddress_wr_i   (sbaddress_wr_i),
    .sbdata_i         (sbdata_i),
    .sbdata_wr_i      (sbdata_wr_i),
    .sbdata_rd_i      (sbdata_rd_i),
    .sbreadonaddr_i   (sbreadonaddr_i),
    .sbreadondata_i   (sbreadondata_i),
    .sbautoinc_i      (sbautoinc_i),
    .sbaccess_i       (sbaccess_i),
    .sberror_sticky_i (sberror_sticky_i),
    .sbbusy_o         (sbbusy_o),
    .sbaddress_o      (sbaddress_o),
    .sbaddress_upd_o  (sbaddress_upd_o),
    .sbdata_o         (sbdata_o),
    .sbdata_valid_o   (sbdata_valid_o),
    .sberror_o        (sberror_o),
    .sberror_valid_o  (sberror_valid_o),
    .req_o            (req_o),
    .addr_o           (addr_o),
    .we_o             (we_o),
    .wdata_o          (wdata_o),
    .be_o             (be_o),
    .gnt_i            (gnt_i),
    .rvalid_i         (rvalid_i),
    .rdata_i          (rdata_i),
    .rerr_i           (rerr_i)
  );

  typedef struct {
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        autoinc;
    logic [2:0]  exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    sbaddress_wr_i = 1'b0;
    sbdata_wr_i    = 1'b0;
    sbdata_rd_i    = 1'b0;
  endtask

  task automatic bus_idle();
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    rerr_i   = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    sbreadonaddr_i = 1'b0;
    sbaddress_i    = a;
    sbaddress_wr_i = 1'b1;
    tick();
    sbaddress_wr_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'h0000_2003, 32'hAB00_0000, 1'b1, 3'd0, 4'h8, 32'h0000_00AB, 32'h0000_2004};
    vecs[1] = '{3'd1, 32'h0000_1002, 32'h1234_5678, 1'b0, 3'd0, 4'hC, 32'h0000_1234, 32'h0000_1002};
    vecs[2] = '{3'd2, 32'h0000_4000, 32'hCAFE_F00D, 1'b1, 3'd0, 4'hF, 32'hCAFE_F00D, 32'h0000_4004};
    vecs[3] = '{3'd0, 32'h0000_5001, 32'h0000_C300, 1'b0, 3'd0, 4'h2, 32'h0000_00C3, 32'h0000_5001};
    vecs[4] = '{3'd1, 32'h0000_3001, 32'h0,         1'b0, 3'd3, 4'h0, 32'h0,         32'h0};
    vecs[5] = '{3'd3, 32'h0000_6000, 32'h0,         1'b0, 3'd4, 4'h0, 32'h0,         32'h0};
    vecs[6] = '{3'd2, 32'h0000_7002, 32'h0,         1'b0, 3'd3, 4'h0, 32'h0,         32'h0};
    vecs[7] = '{3'd1, 32'h0000_8000, 32'hFFFF_5AA5, 1'b1, 3'd0, 4'h3, 32'h0000_5AA5, 32'h0000_8002};
    vecs[8] = '{3'd2, 32'hFFFF_FFFC, 32'h0102_0304, 1'b1, 3'd0, 4'hF, 32'h0102_0304, 32'h0000_0000};

    rst_i = 1'b1;
    sbaddress_i = '0; sbdata_i = '0; rdata_i = '0;
    sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0; sbautoinc_i = 1'b0;
    sbaccess_i = 3'd2; sberror_sticky_i = 1'b0;
    clear_pulses();
    bus_idle();
    repeat (3) tick();
    check("rst_busy", sbbusy_o, 0);
    check("rst_req", req_o, 0);
    check("rst_be", be_o, 0);
    check("rst_addr", sbaddress_o, 0);
    check("rst_pulses", {sbdata_valid_o, sberror_valid_o, sbaddress_upd_o}, 0);
    rst_i = 1'b0;
    tick();

    // Zero-wait reads started by an address write, plus start-time error checks.
    for (int i = 0; i < 9; i++) begin
      sbaccess_i     = vecs[i].access;
      sbautoinc_i    = vecs[i].autoinc;
      sbreadonaddr_i = 1'b1;
      sbaddress_i    = vecs[i].addr;
      sbaddress_wr_i = 1'b1;
      tick();
      sbaddress_wr_i = 1'b0;
      if (vecs[i].exp_err != 3'd0) begin
        check($sformatf("v%0d_err_valid", i), sberror_valid_o, 1);
        check($sformatf("v%0d_err_code", i), sberror_o, vecs[i].exp_err);
        check($sformatf("v%0d_no_req", i), req_o, 0);
        tick();
        check($sformatf("v%0d_no_req_later", i), {req_o, sbbusy_o}, 0);
      end else begin
        check($sformatf("v%0d_req", i), {req_o, we_o}, 2'b10);
        check($sformatf("v%0d_be", i), be_o, vecs[i].exp_be);
        check($sformatf("v%0d_addr_o", i), addr_o, vecs[i].addr);
        gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = vecs[i].rdata;
        tick();
        bus_idle();
        check($sformatf("v%0d_data_valid", i), sbdata_valid_o, 1);
        check($sformatf("v%0d_data", i), sbdata_o, vecs[i].exp_data);
        check($sformatf("v%0d_no_err", i), sberror_valid_o, 0);
        check($sformatf("v%0d_upd", i), sbaddress_upd_o, vecs[i].autoinc);
        if (vecs[i].autoinc) check($sformatf("v%0d_inc_addr", i), sbaddress_o, vecs[i].exp_addr);
        check($sformatf("v%0d_idle", i), sbbusy_o, 0);
      end
      sbreadonaddr_i = 1'b0;
      tick();
    end

    // 32-bit write with grant two cycles after the request.
    sbautoinc_i = 1'b0;
    set_addr(32'h0000_1000);
    sbaccess_i = 3'd2; sbdata_i = 32'hDEAD_BEEF; sbdata_wr_i = 1'b1;
    tick();
    clear_pulses(); sbdata_i = '0;
    check("w32_req_we", {req_o, we_o, sbbusy_o}, 3'b111);
    check("w32_be", be_o, 4'hF);
    check("w32_wdata", wdata_o, 32'hDEAD_BEEF);
    check("w32_addr_o", addr_o, 32'h0000_1000);
    tick();
    check("w32_stable", {req_o, we_o, wdata_o}, {2'b11, 32'hDEAD_BEEF});
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    check("w32_wait", {req_o, sbbusy_o}, 2'b01);
    rvalid_i = 1'b1;
    tick();
    rvalid_i = 1'b0;
    check("w32_done", {sbbusy_o, sberror_valid_o, sbaddress_upd_o, sbdata_valid_o}, 0);

    // Byte write: lane replication and increment by one.
    sbautoinc_i = 1'b1;
    set_addr(32'h0000_1001);
    sbaccess_i = 3'd0; sbdata_i = 32'h0000_005A; sbdata_wr_i = 1'b1;
    tick();
    clear_pulses();
    check("w8_wdata", wdata_o, 32'h5A5A_5A5A);
    check("w8_be", be_o, 4'h2);
    gnt_i = 1'b1; rvalid_i = 1'b1;
    tick();
    bus_idle();
    check("w8_upd", {sbaddress_upd_o, sberror_valid_o, sbdata_valid_o}, 3'b100);
    check("w8_inc_addr", sbaddress_o, 32'h0000_1002);

    // Read returning a bus error.
    sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_i = 32'h0000_2000; sbaddress_wr_i = 1'b1;
    tick();
    clear_pulses(); sbreadonaddr_i = 1'b0;
    gnt_i = 1'b1; rvalid_i = 1'b1; rerr_i = 1'b1;
    tick();
    bus_idle();
    check("rerr_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd7});
    check("rerr_no_data_upd", {sbdata_valid_o, sbaddress_upd_o}, 0);

    // Read on sbdata access at the held address, through WaitRead.
    sbreadondata_i = 1'b1; sbdata_rd_i = 1'b1;
    tick();
    clear_pulses(); sbreadondata_i = 1'b0;
    check("rod_addr_o", addr_o, 32'h0000_2000);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    check("rod_wait", {req_o, sbbusy_o}, 2'b01);
    rvalid_i = 1'b1; rdata_i = 32'h600D_F00D;
    tick();
    bus_idle();
    check("rod_data", {sbdata_valid_o, sbdata_o}, {1'b1, 32'h600D_F00D});
    check("rod_inc_addr", {sbaddress_upd_o, sbaddress_o}, {1'b1, 32'h0000_2004});

    // Timeout after four busy cycles with no grant; a late response is ignored.
    sbreadonaddr_i = 1'b1; sbaddress_i = 32'h0000_9000; sbaddress_wr_i = 1'b1;
    tick();
    clear_pulses(); sbreadonaddr_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("to_req_c%0d", k), {req_o, sberror_valid_o}, 2'b10);
      tick();
    end
    check("to_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd1});
    check("to_idle", {req_o, sbbusy_o, sbaddress_upd_o}, 0);
    rvalid_i = 1'b1; rdata_i = 32'h1111_2222;
    tick();
    rvalid_i = 1'b0;
    check("to_stray_ignored", {sbdata_valid_o, sberror_valid_o, sbaddress_upd_o, sbbusy_o}, 0);
    check("to_no_inc", sbaddress_o, 32'h0000_9000);

    // Reset in WaitWrite with a response arriving in the same cycle.
    set_addr(32'h0000_A000);
    sbaccess_i = 3'd2; sbdata_i = 32'h1122_3344; sbdata_wr_i = 1'b1;
    tick();
    clear_pulses();
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    check("rw_waitwrite", {req_o, sbbusy_o}, 2'b01);
    rst_i = 1'b1; rvalid_i = 1'b1;
    tick();
    check("rw_reset_idle", {sbbusy_o, req_o, sbaddress_upd_o, sberror_valid_o, sbdata_valid_o}, 0);
    check("rw_reset_addr", sbaddress_o, 0);
    rst_i = 1'b0;
    tick();
    rvalid_i = 1'b0;
    check("rw_stray_ignored", {sbbusy_o, sbaddress_upd_o, sberror_valid_o, sbdata_valid_o}, 0);

    // Triggers while busy leave the transfer in flight unchanged.
    sbreadonaddr_i = 1'b1; sbaddress_i = 32'h0000_B000; sbaddress_wr_i = 1'b1;
    tick();
    clear_pulses();
    sbdata_wr_i = 1'b1; sbdata_i = 32'h55; sbaddress_wr_i = 1'b1; sbaddress_i = 32'h0000_C000;
    tick();
    clear_pulses(); sbreadonaddr_i = 1'b0;
    check("busy_trig_ignored", {req_o, we_o, addr_o}, {2'b10, 32'h0000_B000});
    gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h77;
    tick();
    bus_idle();
    check("busy_done_data", {sbdata_valid_o, sbdata_o}, {1'b1, 32'h77});
    check("busy_done_addr", sbaddress_o, 32'h0000_B004);
    tick();
    check("busy_no_new_req", {req_o, sbbusy_o}, 0);

    // Sticky error blocks a new start without reporting anything.
    sberror_sticky_i = 1'b1; sbdata_wr_i = 1'b1;
    tick();
    clear_pulses(); sberror_sticky_i = 1'b0;
    check("sticky_blocks", {req_o, sbbusy_o, sberror_valid_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
